// File: rtl/snake_body_engine.sv
// Snake body store and step engine: segment array, motion, collision and raster query.
// Define SNAKE_WRAP_EN to wrap moves at the board edges instead of dying on the wall.
module snake_body_engine #(
    parameter int GRID_W   = 160,
    parameter int GRID_H   = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int MAX_LEN  = 128,
    parameter int LEN_W    = 8,
    parameter int INIT_LEN = 4,
    parameter int START_X  = 80,
    parameter int START_Y  = 60
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step,
    input  logic [1:0]       dir_in,
    input  logic             grow,
    input  logic [XW-1:0]    query_x,
    input  logic [YW-1:0]    query_y,
    output logic             query_head,
    output logic             query_body,
    output logic [XW-1:0]    head_x,
    output logic [YW-1:0]    head_y,
    output logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             step_done,
    output logic             dead
);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [1:0] D_UP = 2'd0;
    localparam logic [1:0] D_DN = 2'd1;
    localparam logic [1:0] D_LT = 2'd2;
    localparam logic [1:0] D_RT = 2'd3;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_MOVE, S_SHIFT, S_CHECK, S_DEAD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XW-1:0]    r_seg_x [MAX_LEN];
    logic [YW-1:0]    r_seg_y [MAX_LEN];
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [1:0]       r_dir;
    logic             r_grow_pend;
    logic             r_dead;
    logic             r_step_done;
    logic             r_qhead;
    logic             r_qbody;
    logic [XW-1:0]    r_nx;
    logic [YW-1:0]    r_ny;

    logic [XW-1:0]    w_nx;
    logic [YW-1:0]    w_ny;
    logic             w_off;
    logic             w_wall;
    logic             w_rev;
    logic             w_hit;
    logic             w_qhead;
    logic             w_qbody;
    logic [IW-1:0]    w_idx;

    // Next head is always the wrapped neighbour; w_off says whether an edge was crossed
    always_comb begin
        w_nx  = r_seg_x[0];
        w_ny  = r_seg_y[0];
        w_off = 1'b0;
        unique case (r_dir)
            D_UP: begin
                if (r_seg_y[0] == '0) begin
                    w_off = 1'b1;
                    w_ny  = YW'(GRID_H - 1);
                end else begin
                    w_ny = r_seg_y[0] - 1'b1;
                end
            end
            D_DN: begin
                if (r_seg_y[0] == YW'(GRID_H - 1)) begin
                    w_off = 1'b1;
                    w_ny  = '0;
                end else begin
                    w_ny = r_seg_y[0] + 1'b1;
                end
            end
            D_LT: begin
                if (r_seg_x[0] == '0) begin
                    w_off = 1'b1;
                    w_nx  = XW'(GRID_W - 1);
                end else begin
                    w_nx = r_seg_x[0] - 1'b1;
                end
            end
            D_RT: begin
                if (r_seg_x[0] == XW'(GRID_W - 1)) begin
                    w_off = 1'b1;
                    w_nx  = '0;
                end else begin
                    w_nx = r_seg_x[0] + 1'b1;
                end
            end
        endcase
    end

    assign w_wall = w_off & ~WRAP;
    assign w_rev  = ((dir_in ^ r_dir) == 2'b01);
    assign w_idx  = r_idx[IW-1:0];
    assign w_hit  = (r_seg_x[0] == r_seg_x[w_idx]) &&
                    (r_seg_y[0] == r_seg_y[w_idx]);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_READY: if (step) w_state_nxt = S_MOVE;
            S_MOVE:  w_state_nxt = w_wall ? S_DEAD : S_SHIFT;
            S_SHIFT: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_idx >= r_len) w_state_nxt = S_READY;
                else if (w_hit)     w_state_nxt = S_DEAD;
            end
            S_DEAD:  w_state_nxt = S_DEAD;
            default: w_state_nxt = S_IDLE;
        endcase
        if (start) w_state_nxt = S_READY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_dir       <= D_RT;
            r_grow_pend <= 1'b0;
            r_dead      <= 1'b0;
            r_step_done <= 1'b0;
            r_nx        <= '0;
            r_ny        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_done <= 1'b0;
            if (start) begin
                r_len       <= LEN_W'(INIT_LEN);
                r_idx       <= '0;
                r_dir       <= D_RT;
                r_grow_pend <= 1'b0;
                r_dead      <= 1'b0;
            end else begin
                if (grow && r_state != S_IDLE && r_state != S_DEAD)
                    r_grow_pend <= 1'b1;
                unique case (r_state)
                    S_READY: begin
                        if (step && !w_rev) r_dir <= dir_in;
                    end
                    S_MOVE: begin
                        r_nx <= w_nx;
                        r_ny <= w_ny;
                        if (w_wall) r_dead <= 1'b1;
                    end
                    S_SHIFT: begin
                        r_idx <= LEN_W'(1);
                        if (r_grow_pend) begin
                            if (r_len < LEN_W'(MAX_LEN)) r_len <= r_len + 1'b1;
                            // a grow arriving this very cycle belongs to the next step
                            r_grow_pend <= grow;
                        end
                    end
                    S_CHECK: begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx >= r_len) r_step_done <= 1'b1;
                        else if (w_hit)     r_dead      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= '0;
                r_seg_y[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < INIT_LEN; i++) begin
                r_seg_x[i] <= XW'(START_X - i);
                r_seg_y[i] <= YW'(START_Y);
            end
        end else if (r_state == S_SHIFT) begin
            r_seg_x[0] <= r_nx;
            r_seg_y[0] <= r_ny;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
            end
        end
    end

    assign w_qhead = (r_len != '0) &&
                     (r_seg_x[0] == query_x) && (r_seg_y[0] == query_y);

    always_comb begin
        w_qbody = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < r_len) &&
                (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y))
                w_qbody = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_qhead <= 1'b0;
            r_qbody <= 1'b0;
        end else begin
            r_qhead <= w_qhead;
            r_qbody <= w_qbody;
        end
    end

    assign query_head = r_qhead;
    assign query_body = r_qbody;
    assign head_x     = r_seg_x[0];
    assign head_y     = r_seg_y[0];
    assign length     = r_len;
    assign busy       = (r_state == S_MOVE) || (r_state == S_SHIFT) ||
                        (r_state == S_CHECK);
    assign step_done  = r_step_done;
    assign dead       = r_dead;

endmodule
